pwm_demod: RTL

Receive-side counterpart of the sine/PWM tone generator. It takes the complementary `pwm_pos`/`pwm_neg` PWM pair and recovers one signed sample per PWM frame by measuring high-time. It also measures the fundamental tone period in frames from negative-to-positive sample crossings. It sits on the bench/loopback path, or on a board input, to check the generated melody in hardware.

---
 rtl/sound_pkg.sv | 16 +
 rtl/sync2.sv | 27 ++
 rtl/pwm_demod.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/sound_pkg.sv
// Shared types and default constants for the tone generator / demodulator pair.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sound_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } demod_state_t;

    localparam int DAC_PERIOD_DEFAULT     = 511;
    localparam int PITCH_BITWIDTH_DEFAULT = 9;
    localparam int TONE_PERIOD_W          = 16;
    localparam int LOSS_FRAMES_DEFAULT    = 16;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level into the clk domain.
// Latency: 2 clk cycles from input change to q_o.
// Backpressure: none; pure level follower.
// Ports: clk, rst_n (async active-low, clears to 0), d_i async input, q_o synced output.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pwm_demod.sv
// Recovers one signed sample per PWM frame from a pos/neg PWM pair and measures tone period.
// Latency: 2 cycles pin-to-count; sample strobes the cycle after the last frame cycle.
// Backpressure: none; sample_valid/tone_valid are one-cycle strobes that cannot be stalled.
// Ports: clk, reset (async active-low), pwm_pos/pwm_neg async inputs; sample/sample_valid,
//        locked, tone_period/tone_valid, overlap_err (sticky) outputs.
module pwm_demod
    import sound_pkg::*;
#(
    parameter int PITCH_BITWIDTH = PITCH_BITWIDTH_DEFAULT,
    parameter int PERIOD         = DAC_PERIOD_DEFAULT,
    parameter int LOSS_FRAMES    = LOSS_FRAMES_DEFAULT
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            pwm_pos,
    input  logic                            pwm_neg,
    output logic signed [PITCH_BITWIDTH:0]  sample,
    output logic                            sample_valid,
    output logic                            locked,
    output logic [TONE_PERIOD_W-1:0]        tone_period,
    output logic                            tone_valid,
    output logic                            overlap_err
);

    localparam int FC_W  = (PERIOD > 0) ? $clog2(PERIOD + 1) : 1;
    localparam int SIL_W = $clog2(LOSS_FRAMES + 1);
    localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(PERIOD);
    localparam logic [SIL_W-1:0] SIL_LAST = SIL_W'(LOSS_FRAMES - 1);

    logic s_pos, s_neg;
    logic s_pos_dly_q, s_neg_dly_q;

    demod_state_t                   state_q, state_d;
    logic [FC_W-1:0]                fc_q, fc_d;
    logic [PITCH_BITWIDTH-1:0]      pos_cnt_q, pos_cnt_d, neg_cnt_q, neg_cnt_d;
    logic [SIL_W-1:0]               silent_q, silent_d;
    logic signed [PITCH_BITWIDTH:0] sample_q, sample_d;
    logic                           sample_vld_q, sample_vld_d;
    logic [TONE_PERIOD_W-1:0]       frame_ctr_q, frame_ctr_d;
    logic [TONE_PERIOD_W-1:0]       tone_period_q, tone_period_d;
    logic                           tone_vld_q, tone_vld_d;
    logic                           last_neg_q, last_neg_d;
    logic                           seen_q, seen_d;
    logic                           overlap_q, overlap_d;

    sync2 u_sync_pos (.clk(clk), .rst_n(reset), .d_i(pwm_pos), .q_o(s_pos));
    sync2 u_sync_neg (.clk(clk), .rst_n(reset), .d_i(pwm_neg), .q_o(s_neg));

    // Counts including the current cycle, saturating at all-ones.
    logic [PITCH_BITWIDTH-1:0]      pos_inc, neg_inc;
    logic signed [PITCH_BITWIDTH:0] frame_sample;
    logic [TONE_PERIOD_W-1:0]       frame_inc;
    logic                           smp_pos, smp_neg, smp_silent, rise;

    assign pos_inc      = (s_pos && (pos_cnt_q != '1)) ? pos_cnt_q + 1'b1 : pos_cnt_q;
    assign neg_inc      = (s_neg && (neg_cnt_q != '1)) ? neg_cnt_q + 1'b1 : neg_cnt_q;
    assign frame_sample = $signed({1'b0, pos_inc}) - $signed({1'b0, neg_inc});
    assign smp_neg      = frame_sample[PITCH_BITWIDTH];
    assign smp_pos      = !frame_sample[PITCH_BITWIDTH] && (pos_inc != neg_inc);
    assign smp_silent   = (pos_inc == '0) && (neg_inc == '0);
    assign frame_inc    = (frame_ctr_q == '1) ? frame_ctr_q : frame_ctr_q + 1'b1;
    assign rise         = (s_pos && !s_pos_dly_q) || (s_neg && !s_neg_dly_q);

    always_comb begin
        state_d       = state_q;
        fc_d          = fc_q;
        pos_cnt_d     = pos_cnt_q;
        neg_cnt_d     = neg_cnt_q;
        silent_d      = silent_q;
        sample_d      = sample_q;
        sample_vld_d  = 1'b0;
        frame_ctr_d   = frame_ctr_q;
        tone_period_d = tone_period_q;
        tone_vld_d    = 1'b0;
        last_neg_d    = last_neg_q;
        seen_d        = seen_q;
        overlap_d     = overlap_q | (s_pos & s_neg);

        case (state_q)
            SEARCH: begin
                // The detecting cycle is frame cycle 0, so it is counted here.
                if (rise) begin
                    state_d   = LOCKED;
                    fc_d      = FC_W'(1);
                    pos_cnt_d = {{(PITCH_BITWIDTH-1){1'b0}}, s_pos};
                    neg_cnt_d = {{(PITCH_BITWIDTH-1){1'b0}}, s_neg};
                end
            end
            LOCKED: begin
                pos_cnt_d = pos_inc;
                neg_cnt_d = neg_inc;
                if (fc_q == FC_LAST) begin
                    fc_d         = '0;
                    pos_cnt_d    = '0;
                    neg_cnt_d    = '0;
                    sample_d     = frame_sample;
                    sample_vld_d = 1'b1;

                    // Crossing: positive sample after the last nonzero one was negative.
                    if (smp_pos && last_neg_q) begin
                        if (seen_q) begin
                            tone_period_d = frame_inc;
                            tone_vld_d    = 1'b1;
                        end
                        seen_d      = 1'b1;
                        frame_ctr_d = '0;
                    end else begin
                        frame_ctr_d = frame_inc;
                    end
                    if (smp_pos) last_neg_d = 1'b0;
                    if (smp_neg) last_neg_d = 1'b1;

                    if (smp_silent) begin
                        silent_d = silent_q + 1'b1;
                        if (silent_q == SIL_LAST) begin
                            state_d    = SEARCH;
                            silent_d   = '0;
                            last_neg_d = 1'b0;
                            seen_d     = 1'b0;
                        end
                    end else begin
                        silent_d = '0;
                    end
                end else begin
                    fc_d = fc_q + 1'b1;
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_pos_dly_q   <= 1'b0;
            s_neg_dly_q   <= 1'b0;
            state_q       <= SEARCH;
            fc_q          <= '0;
            pos_cnt_q     <= '0;
            neg_cnt_q     <= '0;
            silent_q      <= '0;
            sample_q      <= '0;
            sample_vld_q  <= 1'b0;
            frame_ctr_q   <= '0;
            tone_period_q <= '0;
            tone_vld_q    <= 1'b0;
            last_neg_q    <= 1'b0;
            seen_q        <= 1'b0;
            overlap_q     <= 1'b0;
        end else begin
            s_pos_dly_q   <= s_pos;
            s_neg_dly_q   <= s_neg;
            state_q       <= state_d;
            fc_q          <= fc_d;
            pos_cnt_q     <= pos_cnt_d;
            neg_cnt_q     <= neg_cnt_d;
            silent_q      <= silent_d;
            sample_q      <= sample_d;
            sample_vld_q  <= sample_vld_d;
            frame_ctr_q   <= frame_ctr_d;
            tone_period_q <= tone_period_d;
            tone_vld_q    <= tone_vld_d;
            last_neg_q    <= last_neg_d;
            seen_q        <= seen_d;
            overlap_q     <= overlap_d;
        end
    end

    assign sample       = sample_q;
    assign sample_valid = sample_vld_q;
    assign locked       = (state_q == LOCKED);
    assign tone_period  = tone_period_q;
    assign tone_valid   = tone_vld_q;
    assign overlap_err  = overlap_q;

endmodule
